// File: rtl/sort_frequent_seq_pkg.sv
// Shared constants, FSM encoding and entry sizing for the Huffman front-end
// frequency sorter.
package sort_pkg;

    localparam int N_SYM_DEF    = 4;
    localparam int FREQ_W_DEF   = 4;
    localparam int SYM_W_DEF    = 4;
    localparam int SYM_BASE_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A sort entry is {freq, sym}, so the full entry doubles as the sort key.
    function automatic int entry_width(input int freq_w, input int sym_w);
        return freq_w + sym_w;
    endfunction

endpackage

// File: rtl/sort_frequent_seq_if.sv
// Producer/consumer handshake bundle around the frequency sorter: one
// accept channel from the frequency counter, one result channel to the tree builder.
interface sort_frequent_seq_if
    import sort_pkg::*;
#(
    parameter int N_SYM  = N_SYM_DEF,
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int SYM_W  = SYM_W_DEF
);

    localparam int E    = entry_width(FREQ_W, SYM_W);
    localparam int ZC_W = $clog2(N_SYM + 1);

    logic                    IN_VALID;
    logic                    IN_READY;
    logic [N_SYM*FREQ_W-1:0] FREQ_IN;
    logic                    DESCEND;
    logic                    OUT_VALID;
    logic                    OUT_READY;
    logic [N_SYM*E-1:0]      SORT_OUT;
    logic [ZC_W-1:0]         ZERO_CNT;

    modport slave (
        input  IN_VALID, FREQ_IN, DESCEND, OUT_READY,
        output IN_READY, OUT_VALID, SORT_OUT, ZERO_CNT
    );

    modport master (
        output IN_VALID, FREQ_IN, DESCEND, OUT_READY,
        input  IN_READY, OUT_VALID, SORT_OUT, ZERO_CNT
    );

endinterface

// File: rtl/sort_frequent_seq_cmp_swap.sv
// Combinational compare-exchange cell of the odd-even transposition network;
// out_a receives the entry that belongs first in the selected order.
module sort_cmp_swap
    import sort_pkg::*;
#(
    parameter int E = entry_width(FREQ_W_DEF, SYM_W_DEF)
) (
    input  logic [E-1:0] a,
    input  logic [E-1:0] b,
    input  logic         descend,
    output logic [E-1:0] out_a,
    output logic [E-1:0] out_b
);

    logic swap;

    always_comb begin
        swap  = descend ? (a < b) : (a > b);
        out_a = swap ? b : a;
        out_b = swap ? a : b;
    end

endmodule

// File: rtl/sort_frequent_seq.sv
// Sequential frequency sorter: tags each slot with its symbol code, runs one
// odd-even transposition phase per clock, then offers the result under valid/ready.
module sort_frequent_seq
    import sort_pkg::*;
#(
    parameter int N_SYM    = N_SYM_DEF,
    parameter int FREQ_W   = FREQ_W_DEF,
    parameter int SYM_W    = SYM_W_DEF,
    parameter int SYM_BASE = SYM_BASE_DEF
) (
    input logic               CLK,
    input logic               nRST,
    sort_frequent_seq_if.slave bus
);

    localparam int E    = entry_width(FREQ_W, SYM_W);
    localparam int ZC_W = $clog2(N_SYM + 1);
    localparam int PH_W = $clog2(N_SYM);
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(N_SYM - 1);

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              descend_q, descend_d;
    logic [ZC_W-1:0]   zero_cnt_q, zero_cnt_d;
    logic [E-1:0]      entry_q  [N_SYM];
    logic [E-1:0]      entry_d  [N_SYM];
    logic [E-1:0]      load_val [N_SYM];
    logic [E-1:0]      even_res [N_SYM];
    logic [E-1:0]      odd_res  [N_SYM];
    logic [N_SYM*E-1:0] sort_out;
    logic              in_ready;
    logic              out_valid;

    function automatic logic [ZC_W-1:0] count_zeros(input logic [N_SYM*FREQ_W-1:0] freq);
        logic [ZC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_SYM; i++) begin
            if (freq[i*FREQ_W +: FREQ_W] == '0) cnt = cnt + ZC_W'(1);
        end
        return cnt;
    endfunction

    for (genvar i = 0; i < N_SYM; i++) begin : g_load
        assign load_val[i] = {bus.FREQ_IN[i*FREQ_W +: FREQ_W], SYM_W'(SYM_BASE + i)};
    end

    for (genvar p = 0; p < N_SYM/2; p++) begin : g_even
        sort_cmp_swap #(.E(E)) u_cmp (
            .a       (entry_q[2*p]),
            .b       (entry_q[2*p+1]),
            .descend (descend_q),
            .out_a   (even_res[2*p]),
            .out_b   (even_res[2*p+1])
        );
    end

    // The odd phase leaves both end slots untouched.
    assign odd_res[0]       = entry_q[0];
    assign odd_res[N_SYM-1] = entry_q[N_SYM-1];

    for (genvar p = 0; p < N_SYM/2 - 1; p++) begin : g_odd
        sort_cmp_swap #(.E(E)) u_cmp (
            .a       (entry_q[2*p+1]),
            .b       (entry_q[2*p+2]),
            .descend (descend_q),
            .out_a   (odd_res[2*p+1]),
            .out_b   (odd_res[2*p+2])
        );
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        descend_d  = descend_q;
        zero_cnt_d = zero_cnt_q;
        entry_d    = entry_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.IN_VALID) begin
                    entry_d    = load_val;
                    descend_d  = bus.DESCEND;
                    zero_cnt_d = count_zeros(bus.FREQ_IN);
                    phase_d    = '0;
                    state_d    = ST_SORT;
                end
            end
            ST_SORT: begin
                if (phase_q[0]) entry_d = odd_res;
                else            entry_d = even_res;
                if (phase_q == LAST_PHASE) state_d = ST_DONE;
                else                       phase_d = phase_q + PH_W'(1);
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (bus.OUT_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sort_out = '0;
        for (int k = 0; k < N_SYM; k++) sort_out[k*E +: E] = entry_q[k];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            descend_q  <= 1'b0;
            zero_cnt_q <= '0;
            for (int i = 0; i < N_SYM; i++) entry_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            descend_q  <= descend_d;
            zero_cnt_q <= zero_cnt_d;
            entry_q    <= entry_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid;
    assign bus.SORT_OUT  = sort_out;
    assign bus.ZERO_CNT  = zero_cnt_q;

endmodule

// File: tb/tb_sort_frequent_seq.sv
// Directed bench for sort_frequent_seq: default 4-symbol instance plus an
// 8-symbol instance, with expected results queued at accept time.
module tb_sort_frequent_seq;

    typedef struct packed {
        logic [31:0] so;
        logic [2:0]  zc;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic [63:0] f8;
    logic [95:0] e8;
    int          n8;

    always #5 CLK = ~CLK;

    sort_frequent_seq_if #(.N_SYM(4), .FREQ_W(4), .SYM_W(4)) bus4 ();
    sort_frequent_seq_if #(.N_SYM(8), .FREQ_W(8), .SYM_W(4)) bus8 ();

    sort_frequent_seq #(.N_SYM(4), .FREQ_W(4), .SYM_W(4), .SYM_BASE(10)) dut4 (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus4)
    );

    sort_frequent_seq #(.N_SYM(8), .FREQ_W(8), .SYM_W(4), .SYM_BASE(0)) dut8 (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus8)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start4(input logic [15:0] f, input logic d, input logic push,
                          input logic [31:0] so, input logic [2:0] zc);
        int   n = 0;
        exp_t e;
        bus4.FREQ_IN  = f;
        bus4.DESCEND  = d;
        bus4.IN_VALID = 1'b1;
        while (!bus4.IN_READY && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        check("accept_ready", 128'(bus4.IN_READY), 128'(1));
        if (push) begin
            e.so = so;
            e.zc = zc;
            exp_q.push_back(e);
        end
        @(posedge CLK); #1;
        bus4.IN_VALID = 1'b0;
    endtask

    task automatic wait_out4(input string tag, input int lat);
        int   n = 0;
        exp_t e;
        while (!bus4.OUT_VALID && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'(lat));
        check({tag, "_sb_nonempty"}, 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_sort_out"}, 128'(bus4.SORT_OUT), 128'(e.so));
            check({tag, "_zero_cnt"}, 128'(bus4.ZERO_CNT), 128'(e.zc));
        end
    endtask

    task automatic handshake4(input string tag);
        bus4.OUT_READY = 1'b1;
        @(posedge CLK); #1;
        check({tag, "_valid_drop"}, 128'(bus4.OUT_VALID), 128'(0));
        check({tag, "_ready_back"}, 128'(bus4.IN_READY), 128'(1));
        bus4.OUT_READY = 1'b0;
    endtask

    initial begin
        nRST           = 1'b0;
        bus4.IN_VALID  = 1'b0;
        bus4.FREQ_IN   = '0;
        bus4.DESCEND   = 1'b0;
        bus4.OUT_READY = 1'b0;
        bus8.IN_VALID  = 1'b0;
        bus8.FREQ_IN   = '0;
        bus8.DESCEND   = 1'b0;
        bus8.OUT_READY = 1'b0;

        #12;
        check("rst_out_valid", 128'(bus4.OUT_VALID), 128'(0));
        check("rst_sort_out",  128'(bus4.SORT_OUT),  128'(0));
        check("rst_zero_cnt",  128'(bus4.ZERO_CNT),  128'(0));
        check("rst_in_ready",  128'(bus4.IN_READY),  128'(1));
        check("rst8_sort_out", 128'(bus8.SORT_OUT),  128'(0));
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Ascending, distinct frequencies
        start4(16'h4213, 1'b0, 1'b1, 32'h4D3A2C1B, 3'd0);
        wait_out4("asc", 4);
        handshake4("asc");

        // Frequency ties resolve by symbol code in either direction
        start4(16'h2222, 1'b0, 1'b1, 32'h2D2C2B2A, 3'd0);
        wait_out4("tie_asc", 4);
        handshake4("tie_asc");
        start4(16'h2222, 1'b1, 1'b1, 32'h2A2B2C2D, 3'd0);
        wait_out4("tie_desc", 4);
        handshake4("tie_desc");

        // Zero-frequency symbols
        start4(16'h0500, 1'b0, 1'b1, 32'h5C0D0B0A, 3'd3);
        wait_out4("zeros", 4);
        handshake4("zeros");

        // Backpressure with IN_VALID asserted and changing data
        start4(16'h3141, 1'b0, 1'b1, 32'h4B3D1C1A, 3'd0);
        wait_out4("bp", 4);
        for (int i = 0; i < 10; i++) begin
            bus4.IN_VALID = 1'b1;
            bus4.FREQ_IN  = 16'($urandom);
            bus4.DESCEND  = 1'($urandom);
            @(posedge CLK); #1;
            check("bp_sort_out",  128'(bus4.SORT_OUT),  128'(32'h4B3D1C1A));
            check("bp_out_valid", 128'(bus4.OUT_VALID), 128'(1));
            check("bp_zero_cnt",  128'(bus4.ZERO_CNT),  128'(0));
            check("bp_in_ready",  128'(bus4.IN_READY),  128'(0));
        end
        handshake4("bp");

        // Next vector after backpressure, with OUT_READY raised in advance
        start4(16'h0F70, 1'b1, 1'b1, 32'h0A0D7BFC, 3'd2);
        bus4.OUT_READY = 1'b1;
        wait_out4("adv", 4);
        handshake4("adv");

        // Reset during SORT phase 2 drops the in-flight vector
        start4(16'h0400, 1'b0, 1'b0, 32'h0, 3'd0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        nRST = 1'b0;
        #1;
        check("abort_out_valid", 128'(bus4.OUT_VALID), 128'(0));
        check("abort_sort_out",  128'(bus4.SORT_OUT),  128'(0));
        check("abort_zero_cnt",  128'(bus4.ZERO_CNT),  128'(0));
        check("abort_in_ready",  128'(bus4.IN_READY),  128'(1));
        @(posedge CLK); #1;
        check("abort_hold_valid", 128'(bus4.OUT_VALID), 128'(0));
        nRST = 1'b1;
        @(posedge CLK); #1;
        start4(16'h1234, 1'b0, 1'b1, 32'h4A3B2C1D, 3'd0);
        wait_out4("post_rst", 4);
        handshake4("post_rst");
        check("sb_drained", 128'(exp_q.size()), 128'(0));

        // Eight-symbol instance: slot i frequency 8-i, ascending
        for (int i = 0; i < 8; i++) f8[i*8 +: 8] = 8'(8 - i);
        for (int k = 0; k < 8; k++) e8[k*12 +: 12] = {8'(k + 1), 4'(7 - k)};
        bus8.FREQ_IN  = f8;
        bus8.DESCEND  = 1'b0;
        bus8.IN_VALID = 1'b1;
        check("n8_in_ready", 128'(bus8.IN_READY), 128'(1));
        @(posedge CLK); #1;
        bus8.IN_VALID = 1'b0;
        n8 = 0;
        while (!bus8.OUT_VALID && n8 < 40) begin
            @(posedge CLK); #1;
            n8++;
        end
        check("n8_latency",  128'(n8),            128'(8));
        check("n8_sort_out", 128'(bus8.SORT_OUT), 128'(e8));
        check("n8_zero_cnt", 128'(bus8.ZERO_CNT), 128'(0));
        bus8.OUT_READY = 1'b1;
        @(posedge CLK); #1;
        check("n8_valid_drop", 128'(bus8.OUT_VALID), 128'(0));
        check("n8_ready_back", 128'(bus8.IN_READY),  128'(1));
        bus8.OUT_READY = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
